package_sorter: RTL and testbench

PACKAGE_SORTER -- requirements
Module: package_sorter

---
 rtl/package_sorter_pkg.sv | 39 +++
 rtl/weight_classifier.sv | 31 +++
 rtl/package_sorter.sv | 69 ++++++
 tb/tb_package_sorter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/package_sorter_pkg.sv
// Shared constants for the package sorter: group codes, weight boundaries, counter step.
// Latency: none (declarations and a pure function only).
// Backpressure: none. Macro PACKAGE_SORTER_SATURATE_EN selects saturating counters.
package package_sorter_pkg;

  // Field widths
  localparam int WEIGHT_W = 12;
  localparam int GRP_W    = 3;
  localparam int CNT_W    = 8;
  localparam int NUM_GRPS = 6;

  // Group codes; 0 means nothing is on the scale
  localparam logic [GRP_W-1:0] GRP_NONE = 3'd0;
  localparam logic [GRP_W-1:0] GRP_1    = 3'd1;
  localparam logic [GRP_W-1:0] GRP_2    = 3'd2;
  localparam logic [GRP_W-1:0] GRP_3    = 3'd3;
  localparam logic [GRP_W-1:0] GRP_4    = 3'd4;
  localparam logic [GRP_W-1:0] GRP_5    = 3'd5;
  localparam logic [GRP_W-1:0] GRP_6    = 3'd6;

  // Inclusive upper bounds of groups 1..5; anything above BOUND_5 is group 6
  localparam logic [WEIGHT_W-1:0] BOUND_1 = 12'd250;
  localparam logic [WEIGHT_W-1:0] BOUND_2 = 12'd500;
  localparam logic [WEIGHT_W-1:0] BOUND_3 = 12'd750;
  localparam logic [WEIGHT_W-1:0] BOUND_4 = 12'd1500;
  localparam logic [WEIGHT_W-1:0] BOUND_5 = 12'd2000;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  // Next value of a package counter on an increment: saturate or wrap
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
`ifdef PACKAGE_SORTER_SATURATE_EN
    return (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
`else
    return cnt + 8'd1;
`endif
  endfunction

endpackage

// File: rtl/weight_classifier.sv
// Maps a 12-bit package weight onto its group code (0 = empty scale, 1..6).
// Latency: purely combinational.
// Backpressure: none.
module weight_classifier
  import package_sorter_pkg::*;
(
  input  logic [WEIGHT_W-1:0] weight,
  output logic [GRP_W-1:0]    grp
);

  // Range compare against the shared inclusive boundaries
  always_comb begin
    grp = GRP_NONE;
    if (weight == '0) begin
      grp = GRP_NONE;
    end else if (weight <= BOUND_1) begin
      grp = GRP_1;
    end else if (weight <= BOUND_2) begin
      grp = GRP_2;
    end else if (weight <= BOUND_3) begin
      grp = GRP_3;
    end else if (weight <= BOUND_4) begin
      grp = GRP_4;
    end else if (weight <= BOUND_5) begin
      grp = GRP_5;
    end else begin
      grp = GRP_6;
    end
  end

endmodule

// File: rtl/package_sorter.sv
// Classifies packages by weight and counts distinct packages per group.
// Latency: currentGrp and counters update one clock after weight is sampled.
// Backpressure: none; free-running. Macro PACKAGE_SORTER_SATURATE_EN makes counters saturate at 255.
module package_sorter
  import package_sorter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [WEIGHT_W-1:0] weight,
  output logic [GRP_W-1:0]    currentGrp,
  output logic [CNT_W-1:0]    Grp1,
  output logic [CNT_W-1:0]    Grp2,
  output logic [CNT_W-1:0]    Grp3,
  output logic [CNT_W-1:0]    Grp4,
  output logic [CNT_W-1:0]    Grp5,
  output logic [CNT_W-1:0]    Grp6
);

  logic [GRP_W-1:0] grp;
  logic [GRP_W-1:0] cur_grp;
  logic             prev_zero;
  logic             new_pkg;
  logic [CNT_W-1:0] cnt     [NUM_GRPS];
  logic [CNT_W-1:0] cnt_nxt [NUM_GRPS];

  weight_classifier u_classifier (
    .weight (weight),
    .grp    (grp)
  );

  // A package arrives when the scale goes from empty to loaded
  assign new_pkg = (weight != '0) && prev_zero;

  // Only the counter of the arriving package's group advances
  always_comb begin
    for (int i = 0; i < NUM_GRPS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (new_pkg && (grp == GRP_W'(i + 1))) begin
        cnt_nxt[i] = cnt_next(cnt[i]);
      end
    end
  end

  // State registers; reset wins over any increment in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_grp   <= GRP_NONE;
      prev_zero <= 1'b1;
      for (int i = 0; i < NUM_GRPS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cur_grp   <= grp;
      prev_zero <= (weight == '0);
      for (int i = 0; i < NUM_GRPS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign currentGrp = cur_grp;
  assign Grp1       = cnt[0];
  assign Grp2       = cnt[1];
  assign Grp3       = cnt[2];
  assign Grp4       = cnt[3];
  assign Grp5       = cnt[4];
  assign Grp6       = cnt[5];

endmodule

// File: tb/tb_package_sorter.sv
// Self-checking bench for package_sorter: directed scenarios plus randomized weights vs a reference model.
// Latency: model expects outputs one clock after inputs are sampled.
// Backpressure: none. Honors PACKAGE_SORTER_SATURATE_EN for counter overflow expectations.
module tb_package_sorter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] weight;
  logic [2:0]  currentGrp;
  logic [7:0]  Grp1, Grp2, Grp3, Grp4, Grp5, Grp6;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_grp;
  int m_cnt [6];
  bit m_prev_zero;

  always #5 clk = ~clk;

  package_sorter dut (
    .clk        (clk),
    .reset      (reset),
    .weight     (weight),
    .currentGrp (currentGrp),
    .Grp1       (Grp1),
    .Grp2       (Grp2),
    .Grp3       (Grp3),
    .Grp4       (Grp4),
    .Grp5       (Grp5),
    .Grp6       (Grp6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Group from the weight table: first group whose upper bound covers w
  function automatic int classify(input int w);
    int ub [7] = '{0, 250, 500, 750, 1500, 2000, 4095};
    if (w == 0) return 0;
    for (int k = 1; k <= 6; k++) begin
      if (w <= ub[k]) return k;
    end
    return 6;
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(Grp1);
      1: return int'(Grp2);
      2: return int'(Grp3);
      3: return int'(Grp4);
      4: return int'(Grp5);
      default: return int'(Grp6);
    endcase
  endfunction

  // Drive one cycle, advance the model at the edge, compare on the falling edge
  task automatic cycle(input int w, input bit r);
    int g;
    weight = 12'(w);
    reset  = r;
    @(posedge clk);
    if (!r) begin
      m_grp = 0;
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_prev_zero = 1'b1;
    end else begin
      g = classify(w);
      m_grp = g;
      if (w != 0 && m_prev_zero) begin
`ifdef PACKAGE_SORTER_SATURATE_EN
        if (m_cnt[g-1] < 255) m_cnt[g-1]++;
`else
        m_cnt[g-1] = (m_cnt[g-1] + 1) % 256;
`endif
      end
      m_prev_zero = (w == 0);
    end
    @(negedge clk);
    check("currentGrp", 32'(currentGrp), 32'(m_grp));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("Grp%0d", i + 1), 32'(dut_cnt(i)), 32'(m_cnt[i]));
    end
  endtask

  task automatic hold(input int w, input int n);
    repeat (n) cycle(w, 1'b1);
  endtask

  initial begin
    int sweep_w [11] = '{250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};
    int sweep_g [11] = '{1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
    int edge_w  [12] = '{1, 250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};
    int w, n;
    bit r;

    reset  = 1'b0;
    weight = '0;

    // Reset state
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    check("rst_currentGrp", 32'(currentGrp), 32'd0);
    check("rst_Grp1", 32'(Grp1), 32'd0);
    check("rst_Grp6", 32'(Grp6), 32'd0);

    // Basic sequence
    hold(270, 3); hold(0, 2); hold(300, 3); hold(0, 2); hold(501, 3); hold(1013, 3);
    check("seq1_Grp2", 32'(Grp2), 32'd2);
    check("seq1_Grp3", 32'(Grp3), 32'd1);
    check("seq1_Grp4", 32'(Grp4), 32'd0);
    check("seq1_currentGrp", 32'(currentGrp), 32'd4);

    // Continuation with single-cycle zero gaps
    hold(0, 1); hold(1, 3); hold(0, 1); hold(250, 3); hold(0, 1); hold(2001, 3);
    check("seq2_Grp1", 32'(Grp1), 32'd2);
    check("seq2_Grp2", 32'(Grp2), 32'd2);
    check("seq2_Grp3", 32'(Grp3), 32'd1);
    check("seq2_Grp4", 32'(Grp4), 32'd0);
    check("seq2_Grp5", 32'(Grp5), 32'd0);
    check("seq2_Grp6", 32'(Grp6), 32'd1);
    check("seq2_currentGrp", 32'(currentGrp), 32'd6);

    // Boundary sweep from a clean reset
    cycle(0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      hold(sweep_w[i], 1);
      check($sformatf("sweep_grp_%0d", sweep_w[i]), 32'(currentGrp), 32'(sweep_g[i]));
      hold(0, 1);
    end
    check("sweep_Grp1", 32'(Grp1), 32'd1);
    check("sweep_Grp2", 32'(Grp2), 32'd2);
    check("sweep_Grp3", 32'(Grp3), 32'd2);
    check("sweep_Grp4", 32'(Grp4), 32'd2);
    check("sweep_Grp5", 32'(Grp5), 32'd2);
    check("sweep_Grp6", 32'(Grp6), 32'd2);

    // Long hold counts once
    cycle(0, 1'b0);
    hold(800, 1);
    check("hold_first_grp", 32'(currentGrp), 32'd4);
    hold(800, 19);
    check("hold_Grp4", 32'(Grp4), 32'd1);
    check("hold_currentGrp", 32'(currentGrp), 32'd4);
    hold(0, 1);

    // Counter overflow on group 1
    cycle(0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      hold(1, 1);
      hold(0, 1);
    end
`ifdef PACKAGE_SORTER_SATURATE_EN
    check("ovf_Grp1", 32'(Grp1), 32'd255);
`else
    check("ovf_Grp1", 32'(Grp1), 32'd0);
`endif

    // Reset asserted while a package sits on the scale
    hold(600, 2);
    cycle(600, 1'b0);
    check("midrst_currentGrp", 32'(currentGrp), 32'd0);
    check("midrst_Grp3", 32'(Grp3), 32'd0);
    check("midrst_Grp1", 32'(Grp1), 32'd0);
    cycle(600, 1'b0);
    check("midrst2_Grp3", 32'(Grp3), 32'd0);
    cycle(600, 1'b1);
    check("postrst_Grp3", 32'(Grp3), 32'd1);
    check("postrst_currentGrp", 32'(currentGrp), 32'd3);

    // Randomized traffic with occasional resets
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: w = 0;
        3, 4, 5: w = edge_w[$urandom_range(0, 11)];
        default: w = $urandom_range(1, 4095);
      endcase
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        r = ($urandom_range(0, 99) != 0);
        cycle(w, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
